// File: rtl/tick_scheduler.sv
// tick_scheduler: base tick divider with programmable per-channel tick enables and run/pause/step/stop control.
// Define TICK_SCHED_SLOWCLK_EN to add the slow_clk square-wave output.
module tick_scheduler #(
  parameter int BASE_DIV = 1000000,
  parameter int NUM_CH = 4,
  parameter int PER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              pause_req,
  input  logic              step_req,
  input  logic              stop_req,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [1:0]        state
`ifdef TICK_SCHED_SLOWCLK_EN
  ,
  output logic              slow_clk
`endif
);
  localparam int CW = $clog2(BASE_DIV);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, STEP = 2'b11} st_t;
  st_t st;
  logic [CW-1:0] cnt;
  logic counting, term, base_ev;
  assign counting = (st == RUN || st == STEP) && !stop_req;
  assign term = cnt == CW'(BASE_DIV - 1);
  assign base_ev = counting && term;
  assign state = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= base_ev;
      cnt <= (stop_req || (st == IDLE && run_req)) ? '0 : counting ? (term ? '0 : cnt + CW'(1)) : cnt;
      if (stop_req) st <= IDLE;
      else
        case (st)
          IDLE:  if (run_req) st <= RUN;
          RUN:   if (pause_req) st <= PAUSE;
          PAUSE: if (run_req) st <= RUN; else if (step_req) st <= STEP;
          STEP:  if (run_req) st <= RUN; else if (term) st <= PAUSE;
        endcase
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PER_W-1:0] per, ch_cnt;
    logic wr, hit, tk;
    assign wr = cfg_we && cfg_ch == 3'(i);
    assign hit = ch_cnt == per - PER_W'(1);
    assign tick[i] = tk;
    // a period write on the terminal base tick cancels that tick and restarts the phase
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        per <= '0;
        ch_cnt <= '0;
        tk <= 1'b0;
      end else begin
        tk <= base_ev && per != '0 && hit && !wr;
        if (wr) per <= cfg_period;
        ch_cnt <= (wr || stop_req || per == '0) ? '0 : base_ev ? (hit ? '0 : ch_cnt + PER_W'(1)) : ch_cnt;
      end
  end
`ifdef TICK_SCHED_SLOWCLK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slow_clk <= 1'b0;
    else slow_clk <= stop_req ? 1'b0 : slow_clk ^ base_ev;
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench for tick_scheduler with BASE_DIV=4, four channels.
module tb_tick_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic run_req = 1'b0, pause_req = 1'b0, step_req = 1'b0, stop_req = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic base_tick;
  logic [3:0] tick;
  logic [1:0] state;
`ifdef TICK_SCHED_SLOWCLK_EN
  logic slow_clk;
`endif
  int checks = 0, errors = 0;
  typedef struct { int at; logic [4:0] v; } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  tick_scheduler #(.BASE_DIV(4), .NUM_CH(4), .PER_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .pause_req(pause_req), .step_req(step_req),
    .stop_req(stop_req), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .base_tick(base_tick), .tick(tick), .state(state)
`ifdef TICK_SCHED_SLOWCLK_EN
    , .slow_clk(slow_clk)
`endif
  );

  // r = {stop, step, pause, run}; held across exactly one rising edge
  task automatic pulse(input logic [3:0] r);
    {stop_req, step_req, pause_req, run_req} = r;
    @(negedge clk);
    {stop_req, step_req, pause_req, run_req} = '0;
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [7:0] p);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (base_tick !== 1'b0) begin errors++; $display("FAIL reset_base got %b exp 0", base_tick); end
    checks++; if (tick !== 4'b0) begin errors++; $display("FAIL reset_tick got %b exp 0000", tick); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_base;
    logic [4:0] e;
    ev_t t;
    pulse(4'b0001);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL base_state got %b exp 01", state); end
    for (int j = 1; j <= 3; j++) q.push_back('{4 * j, 5'b10000});
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL base k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
    pulse(4'b1000);
  endtask

  task automatic test_channels;
    logic [4:0] e;
    ev_t t;
    cfg(3'd0, 8'd1);
    cfg(3'd1, 8'd3);
    cfg(3'd2, 8'd0);
    pulse(4'b0001);
    for (int j = 1; j <= 9; j++) q.push_back('{4 * j, {3'b100, j % 3 == 0, 1'b1}});
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL channels k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
    pulse(4'b1000);
  endtask

  task automatic test_pause;
    logic [4:0] e;
    ev_t t;
    pulse(4'b0001);
    q.push_back('{4, 5'b10001});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL pre_pause k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
    pulse(4'b0010);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state got %b exp 10", state); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++; if ({base_tick, tick} !== 5'b0) begin errors++; $display("FAIL paused k=%0d got %b exp 00000", k, {base_tick, tick}); end
    end
    pulse(4'b0001);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL resume_state got %b exp 01", state); end
    q.push_back('{3, 5'b10001});
    q.push_back('{7, 5'b10011});
    q.push_back('{11, 5'b10001});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL resume k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
    pulse(4'b1000);
  endtask

  task automatic test_step;
    repeat (2) @(negedge clk);
    pulse(4'b0001);
    repeat (2) @(negedge clk);
    pulse(4'b0010);
    pulse(4'b0100);
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL step_state got %b exp 11", state); end
    @(negedge clk);
    checks++; if ({base_tick, tick} !== 5'b10001) begin errors++; $display("FAIL step_tick got %b exp 10001", {base_tick, tick}); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL step_return got %b exp 10", state); end
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      checks++; if ({base_tick, tick, state} !== 7'b0000010) begin errors++; $display("FAIL step_hold k=%0d got %b exp 0000010", k, {base_tick, tick, state}); end
    end
    pulse(4'b1000);
  endtask

  task automatic test_cfg_collide;
    logic [4:0] e;
    ev_t t;
    cfg(3'd5, 8'd1);
    pulse(4'b0001);
    for (int j = 1; j <= 7; j++) q.push_back('{4 * j, {3'b100, j == 6, 1'b1}});
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (k == 12) cfg_we = 1'b0;
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL collide k=%0d got %b exp %b", k, {base_tick, tick}, e); end
      if (k == 11) begin cfg_we = 1'b1; cfg_ch = 3'd1; cfg_period = 8'd3; end
    end
    pulse(4'b1000);
  endtask

  task automatic test_stop;
    logic [4:0] e;
    ev_t t;
    pulse(4'b0001);
    q.push_back('{4, 5'b10001});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL pre_stop k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
    pulse(4'b1011);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL stop_state got %b exp 00", state); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if ({base_tick, tick, state} !== 7'b0) begin errors++; $display("FAIL stopped k=%0d got %b exp 0000000", k, {base_tick, tick, state}); end
    end
    pulse(4'b0001);
    for (int j = 1; j <= 3; j++) q.push_back('{4 * j, {3'b100, j == 3, 1'b1}});
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL restart k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
    pulse(4'b1000);
  endtask

  task automatic test_async_reset;
    logic [4:0] e;
    ev_t t;
    pulse(4'b0001);
    repeat (4) @(negedge clk);
    checks++; if ({base_tick, tick} !== 5'b10001) begin errors++; $display("FAIL pre_reset got %b exp 10001", {base_tick, tick}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({base_tick, tick, state} !== 7'b0) begin errors++; $display("FAIL async_reset got %b exp 0000000", {base_tick, tick, state}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(4'b0001);
    q.push_back('{4, 5'b10000});
    q.push_back('{8, 5'b10000});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = '0;
      if (q.size() != 0 && q[0].at == k) begin t = q.pop_front(); e = t.v; end
      checks++; if ({base_tick, tick} !== e) begin errors++; $display("FAIL post_reset k=%0d got %b exp %b", k, {base_tick, tick}, e); end
    end
  endtask

  initial begin
    test_reset;
    test_base;
    test_channels;
    test_pause;
    test_step;
    test_cfg_collide;
    test_stop;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
